// File: rtl/mem_pkg.sv
// Purpose: shared types and helpers for the LSU memory master (access size, FSM state, size-to-mask).
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: size_e (SZ_B/SZ_H/SZ_W/SZ_X), state_e (IDLE/ACC0/ACC1/RESP), size2mask(), size2bytes().
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_X = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Right-justified byte-enable pattern for an access size; illegal size enables nothing.
  function automatic logic [3:0] size2mask(input logic [1:0] size);
    logic [3:0] m;
    case (size_e'(size))
      SZ_B:    m = 4'b0001;
      SZ_H:    m = 4'b0011;
      SZ_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Number of bytes touched; 0 for the illegal size so it never looks word-crossing.
  function automatic logic [2:0] size2bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size_e'(size))
      SZ_B:    n = 3'd1;
      SZ_H:    n = 3'd2;
      SZ_W:    n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Purpose: lane alignment for the LSU memory master: store mask/data shift and load extract + extend.
// Latency: zero cycles, purely combinational.
// Backpressure: none; no handshake on either path.
// Ports:
//   st_off_i, st_size_i, st_wdata_i  store-side byte offset, size, right-justified data
//   st_lanes_o                       8-lane mask spanning two consecutive words
//   st_wide_o                        64-bit lane-positioned data spanning two words
//   ld_off_i, ld_size_i, ld_unsigned_i, ld_buf_i  load-side offset, size, zero-extend flag, 64-bit read buffer
//   ld_data_o                        extracted and sign/zero-extended load result
module lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]  st_off_i,
  input  logic [1:0]  st_size_i,
  input  logic [31:0] st_wdata_i,
  output logic [7:0]  st_lanes_o,
  output logic [63:0] st_wide_o,
  input  logic [1:0]  ld_off_i,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_unsigned_i,
  input  logic [63:0] ld_buf_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_raw;

  assign st_lanes_o = {4'b0000, size2mask(st_size_i)} << st_off_i;
  assign st_wide_o  = {32'h0000_0000, st_wdata_i} << {st_off_i, 3'b000};

  // Bring the addressed byte down to lane 0; only the low word is ever needed.
  assign ld_raw = 32'(ld_buf_i >> {ld_off_i, 3'b000});

  always_comb begin
    ld_data_o = ld_raw;
    case (size_e'(ld_size_i))
      SZ_B:    ld_data_o = {{24{~ld_unsigned_i & ld_raw[7]}}, ld_raw[7:0]};
      SZ_H:    ld_data_o = {{16{~ld_unsigned_i & ld_raw[15]}}, ld_raw[15:0]};
      default: ld_data_o = ld_raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Purpose: LSU-side initiator of the combinational pmem bus; byte/half/word loads and stores, misaligned split in two.
// Latency: from accept cycle T, rsp_valid at T+2 aligned, T+3 split, T+1 on error; one request in flight.
// Backpressure: req_ready stays low from accept until the response handshake; response held while !rsp_ready.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   req_valid/req_ready, req_we, req_addr, req_size, req_unsigned, req_wdata   request channel
//   rsp_valid/rsp_ready, rsp_rdata, rsp_err                                    response channel
//   mem_req, mem_we, mem_addr, mem_mask, mem_wdata, mem_rdata                  pmem bus (rdata same cycle)
module lsu_mem_master
  import mem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_mask,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e            state_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_mask_q;
  logic [31:0]       mem_wdata_q;

  // Captured request; the live req_* inputs may change freely after accept.
  logic              we_q;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              cross_q;
  logic [3:0]        hi_mask_q;
  logic [31:0]       hi_wdata_q;
  logic [63:0]       buf_q;

  logic [7:0]        st_lanes;
  logic [63:0]       st_wide;
  logic [31:0]       ld_data;
  logic [2:0]        acc_end;
  logic              acc_cross;
  logic              acc_err;

  // Store alignment works on the live request so ACC0 outputs can be registered at accept;
  // load extraction works on the captured fields and the filled read buffer.
  lsu_align u_align (
    .st_off_i      (req_addr[1:0]),
    .st_size_i     (req_size),
    .st_wdata_i    (req_wdata),
    .st_lanes_o    (st_lanes),
    .st_wide_o     (st_wide),
    .ld_off_i      (off_q),
    .ld_size_i     (size_q),
    .ld_unsigned_i (uns_q),
    .ld_buf_i      (buf_q),
    .ld_data_o     (ld_data)
  );

  // One past the last byte touched; beyond 4 means the access spills into the next word.
  assign acc_end   = {1'b0, req_addr[1:0]} + size2bytes(req_size);
  assign acc_cross = (acc_end > 3'd4);
  assign acc_err   = (req_size == SZ_X) || (acc_cross && (SPLIT_EN == 1'b0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_mask_q  <= '0;
      mem_wdata_q <= '0;
      we_q        <= 1'b0;
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      cross_q     <= 1'b0;
      hi_mask_q   <= '0;
      hi_wdata_q  <= '0;
      buf_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            we_q        <= req_we;
            off_q       <= req_addr[1:0];
            size_q      <= req_size;
            uns_q       <= req_unsigned;
            cross_q     <= acc_cross;
            hi_mask_q   <= st_lanes[7:4];
            hi_wdata_q  <= st_wide[63:32];
            if (acc_err) begin
              // Rejected without touching memory.
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q     <= ST_ACC0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_we;
              mem_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_mask_q  <= {4'b0000, st_lanes[3:0]};
              mem_wdata_q <= st_wide[31:0];
            end
          end
        end

        ST_ACC0: begin
          buf_q[31:0] <= mem_rdata;
          if (cross_q) begin
            // Second word: address wraps naturally at the top of the space.
            state_q     <= ST_ACC1;
            mem_addr_q  <= mem_addr_q + ADDR_W'(4);
            mem_mask_q  <= {4'b0000, hi_mask_q};
            mem_wdata_q <= hi_wdata_q;
          end else begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_mask_q  <= '0;
            mem_wdata_q <= '0;
          end
        end

        ST_ACC1: begin
          buf_q[63:32] <= mem_rdata;
          state_q      <= ST_RESP;
          rsp_valid_q  <= 1'b1;
          mem_req_q    <= 1'b0;
          mem_we_q     <= 1'b0;
          mem_addr_q   <= '0;
          mem_mask_q   <= '0;
          mem_wdata_q  <= '0;
        end

        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_mask  = mem_mask_q;
  assign mem_wdata = mem_wdata_q;

  // Load data is decoded from registers only (buffer and captured fields), so it is
  // glitch-free and holds steady for the whole RESP stall; stores and errors read as 0.
  assign rsp_rdata = ((state_q == ST_RESP) && !we_q && !rsp_err_q) ? ld_data : 32'h0000_0000;

endmodule
